// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges single-cycle cache line requests to four-beat memory bursts.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   address_i, read_i, write_i    cache-side request
//   line_i / line_o               line to write / line from last completed read
//   resp_o                        one-cycle completion pulse to the cache
//   address_o, read_o, write_o    memory-side request, address line-aligned
//   burst_o / burst_i, resp_i     write beat / read beat, beat-valid strobe
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, next;
  logic [1:0] k;
  logic [LINE_W-1:0] line_r;
  logic [31:0] addr_r;
  logic beat, start;
  assign start     = state == IDLE && (read_i || write_i);
  assign beat      = resp_i && (state == READ || state == WRITE);
  assign read_o    = state == READ;
  assign write_o   = state == WRITE;
  assign resp_o    = state == DONE;
  assign address_o = addr_r;
  assign burst_o   = write_o ? line_r[BURST_W*k +: BURST_W] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    next = state == IDLE ? (write_i ? WRITE : read_i ? READ : IDLE)
         : state == DONE ? IDLE
         : (beat && k == 2'd3) ? DONE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k      <= '0;
      line_r <= '0;
      addr_r <= '0;
      line_o <= '0;
    end else if (start) begin
      k      <= '0;
      addr_r <= address_i & ~32'h1f;
      if (write_i) line_r <= line_i;
    end else if (beat) begin
      k <= k + 2'd1;
      if (state == READ) line_o[BURST_W*k +: BURST_W] <= burst_i;
    end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed self-checking bench for cacheline_adaptor.
module tb_cacheline_adaptor;
  logic clk = 0, rst = 1;
  logic [31:0] address_i = '0, address_o;
  logic read_i = 0, write_i = 0, resp_i = 0;
  logic [255:0] line_i = '0, line_o;
  logic resp_o, read_o, write_o;
  logic [63:0] burst_o, burst_i = '0;
  int n_cmp = 0, n_bad = 0;
  localparam logic [255:0] L1 = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
  localparam logic [255:0] L2 = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                                 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
  localparam logic [255:0] LW = {{16{4'hd}}, {16{4'hc}}, {16{4'hb}}, {16{4'ha}}};
  localparam logic [255:0] LW2 = {64'h0f0f_0f0f_0000_0004, 64'h0f0f_0f0f_0000_0003,
                                  64'h0f0f_0f0f_0000_0002, 64'h0f0f_0f0f_0000_0001};
  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] a_exp, input logic [15:0] pat,
                    input int n, input logic [255:0] exp);
    int b = 0;
    address_i = a;
    read_i = 1;
    tick;
    read_i = 0;
    chk("rd_read_o", read_o, 1);
    chk("rd_write_o", write_o, 0);
    chk("rd_addr", address_o, a_exp);
    for (int i = 0; i < n; i++) begin
      resp_i = pat[i];
      burst_i = pat[i] ? exp[64*b +: 64] : 64'hbad0_bad0_bad0_bad0;
      tick;
      if (pat[i]) b++;
      chk("rd_read_o_beat", read_o, b < 4);
      chk("rd_resp_o", resp_o, b == 4);
    end
    resp_i = 0;
    chk("rd_line", line_o, exp);
    tick;
    chk("rd_resp_gone", resp_o, 0);
    chk("rd_line_hold", line_o, exp);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] a_exp, input logic [255:0] line,
                    input logic [15:0] pat, input int n, input logic both,
                    input logic [255:0] keep);
    int b = 0;
    address_i = a;
    line_i = line;
    write_i = 1;
    read_i = both;
    tick;
    write_i = 0;
    read_i = 0;
    line_i = '0;
    chk("wr_write_o", write_o, 1);
    chk("wr_read_o", read_o, 0);
    chk("wr_addr", address_o, a_exp);
    for (int i = 0; i < n; i++) begin
      chk("wr_burst", burst_o, line[64*b +: 64]);
      resp_i = pat[i];
      read_i = i == 1;
      tick;
      read_i = 0;
      if (pat[i]) b++;
      chk("wr_write_o_beat", write_o, b < 4);
      chk("wr_resp_o", resp_o, b == 4);
    end
    resp_i = 0;
    chk("wr_line_o_kept", line_o, keep);
    chk("wr_burst_done", burst_o, 0);
    tick;
    chk("wr_resp_gone", resp_o, 0);
    chk("wr_no_read", read_o, 0);
  endtask
  initial begin
    #2;
    chk("rst_resp", resp_o, 0);
    chk("rst_read", read_o, 0);
    chk("rst_write", write_o, 0);
    chk("rst_line", line_o, 0);
    chk("rst_burst", burst_o, 0);
    chk("rst_addr", address_o, 0);
    address_i = 32'hffff_ffff;
    read_i = 1;
    tick;
    chk("rst_hold_read", read_o, 0);
    read_i = 0;
    tick;
    rst = 0;
    resp_i = 1;
    tick;
    resp_i = 0;
    chk("idle_resp_ignored", resp_o, 0);
    rd(32'h1234_567f, 32'h1234_5660, 16'h000f, 4, L1);
    wr(32'h0000_abcd, 32'h0000_abc0, LW, 16'h000f, 4, 1, L1);
    rd(32'h8000_003f, 32'h8000_0020, 16'h0059, 7, L2);
    wr(32'h0000_0021, 32'h0000_0020, LW2, 16'h002d, 6, 0, L2);
    address_i = 32'h0000_1000;
    read_i = 1;
    tick;
    read_i = 0;
    resp_i = 1;
    burst_i = 64'h5555_5555_5555_5555;
    tick;
    burst_i = 64'h6666_6666_6666_6666;
    tick;
    resp_i = 0;
    chk("mid_read_o", read_o, 1);
    #2 rst = 1;
    #1;
    chk("async_read", read_o, 0);
    chk("async_line", line_o, 0);
    chk("async_addr", address_o, 0);
    chk("async_resp", resp_o, 0);
    #1 rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_resp", resp_o, 0);
      chk("post_rst_read", read_o, 0);
    end
    rd(32'h0000_0040, 32'h0000_0040, 16'h001b, 5, L2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter LINE_W, default 256: cache line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64: memory beat width; LINE_W SHALL equal 4*BURST_W.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port address_i  input  32  cache-side line address.
REQ-006 SHALL have port read_i  input  1  cache-side line read request.
REQ-007 SHALL have port write_i  input  1  cache-side line write request.
REQ-008 SHALL have port line_i  input  LINE_W  line to write.
REQ-009 SHALL have port line_o  output  LINE_W  line returned by the last completed read.
REQ-010 SHALL have port resp_o  output  1  one-cycle completion pulse to the cache.
REQ-011 SHALL have port address_o  output  32  memory-side address, line-aligned.
REQ-012 SHALL have port read_o  output  1  memory read request.
REQ-013 SHALL have port write_o  output  1  memory write request.
REQ-014 SHALL have port burst_o  output  BURST_W  write beat data.
REQ-015 SHALL have port burst_i  input  BURST_W  read beat data.
REQ-016 SHALL have port resp_i  input  1  memory beat-valid strobe.

Function
REQ-017 SHALL implement the FSM states IDLE, READ, WRITE and DONE, plus a 2-bit beat counter k.
REQ-018 In IDLE with write_i=1, SHALL latch line_i and {address_i[31:5],5'b0}, clear k, and go to WRITE; write_i SHALL win when read_i is also 1.
REQ-019 In IDLE with read_i=1 and write_i=0, SHALL latch the aligned address, clear k, and go to READ.
REQ-020 read_o SHALL be 1 exactly while in READ, and write_o exactly while in WRITE; address_o SHALL hold the latched address in both states.
REQ-021 In READ, each cycle with resp_i=1 SHALL capture burst_i into line_o[BURST_W*k +: BURST_W] and increment k; beat 0 SHALL map to bits [63:0].
REQ-022 In WRITE, burst_o SHALL equal latched_line[BURST_W*k +: BURST_W] combinationally, and each cycle with resp_i=1 SHALL increment k.
REQ-023 Cycles with resp_i=0 in READ/WRITE SHALL hold k and all data; gaps between beats SHALL be tolerated.
REQ-024 The edge that consumes the beat with k=3 SHALL move to DONE; k SHALL wrap to 0.
REQ-025 DONE SHALL assert resp_o=1 for exactly one cycle, with read_o=write_o=0, and then return to IDLE unconditionally.
REQ-026 Minimum latency SHALL be: request sampled at edge E0, beats at E1..E4, resp_o high in the cycle after E4.
REQ-027 line_o SHALL be stable from resp_o until the next read's first captured beat; writes SHALL NOT alter line_o.
REQ-028 read_i/write_i outside IDLE, and resp_i in IDLE or DONE, SHALL be ignored.
REQ-029 burst_o SHALL be 0 outside WRITE.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, k=0, line_o=0, the latched line and address to 0, and resp_o=read_o=write_o=0, independent of clk.
REQ-031 Reset asserted mid-burst SHALL abandon the transfer with no resp_o; the first request after deassertion SHALL be handled normally.

Verification
REQ-032 Read with back-to-back beats: address_i=0x1234_567F, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x1234_5660; line_o={44..,33..,22..,11..}; resp_o pulses exactly 5 cycles after request.
REQ-033 Write with line_i={D,C,B,A} and resp_i high for 4 cycles -> burst_o=A,B,C,D in successive resp_i cycles; write_o drops as resp_o pulses; line_o unchanged.
REQ-034 Read with resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order; resp_o one cycle after the 7th cycle.
REQ-035 read_i=write_i=1 in IDLE -> write_o=1, read_o=0; a read_i toggled during the burst is ignored.
REQ-036 rst pulse between an edge after beat 2 of a read and the next edge -> outputs 0 asynchronously; no resp_o; a subsequent read completes with correct data.
